// File: rtl/top_control.sv
// top_control: 16-bit accumulator processor core.
//   Contains a 512-word instruction RAM, a 512-word data RAM, the register
//   file (PC, AR, IR, AC, R, Z), the ALU and the multi-cycle control FSM.
//   Both RAMs can be loaded through the external load port while start=0.
// Ports:
//   clock, reset              - rising-edge clock, asynchronous active-high reset
//   start                     - run enable (FSM drops to IDLE when low)
//   start_2 / start_3         - IRAM / DRAM external-load mode (start_2 wins)
//   addr_ext, *_write_ext     - external load address and write strobes
//   Data_in_ins, Data_in_dram - external load data
//   iram_in, dram_in          - registered RAM read data
//   dram_out                  - DRAM write data (AC)
//   pc_out, ar_out, state     - architectural state for debug
//   control_out               - packed control word
//   data_in_pc                - next PC value
//   alu_in_1, alu_in_2, alu_out - ALU operands and result
//   write_en, read_en         - memory control from the core
module top_control (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        start_2,
   input  logic        start_3,
   input  logic [8:0]  addr_ext,
   input  logic        iram_write_ext,
   input  logic        dram_write_ext,
   input  logic [15:0] Data_in_ins,
   input  logic [15:0] Data_in_dram,
   output logic [15:0] iram_in,
   output logic [15:0] dram_in,
   output logic [15:0] dram_out,
   output logic [15:0] pc_out,
   output logic [15:0] ar_out,
   output logic [19:0] control_out,
   output logic [5:0]  state,
   output logic [15:0] data_in_pc,
   output logic [15:0] alu_in_1,
   output logic [15:0] alu_in_2,
   output logic [15:0] alu_out,
   output logic        write_en,
   output logic [1:0]  read_en
);

   localparam logic [5:0] S_IDLE   = 6'd0;
   localparam logic [5:0] S_FETCH1 = 6'd1;
   localparam logic [5:0] S_FETCH2 = 6'd2;
   localparam logic [5:0] S_DECODE = 6'd3;
   localparam logic [5:0] S_LD1    = 6'd4;
   localparam logic [5:0] S_LD2    = 6'd5;
   localparam logic [5:0] S_ST     = 6'd6;
   localparam logic [5:0] S_ALU    = 6'd7;
   localparam logic [5:0] S_JMP    = 6'd8;
   localparam logic [5:0] S_HALT   = 6'd63;

   localparam logic [3:0] ALU_PASSA = 4'd0;
   localparam logic [3:0] ALU_PASSB = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SUB   = 4'd3;
   localparam logic [3:0] ALU_INC   = 4'd4;
   localparam logic [3:0] ALU_AND   = 4'd5;
   localparam logic [3:0] ALU_OR    = 4'd6;
   localparam logic [3:0] ALU_MUL   = 4'd7;

   logic [5:0]  state_reg, state_next;
   logic [15:0] pc_reg, ar_reg, ac_reg, r_reg;
   // Only the opcode and address fields of IR are ever consumed, so bits
   // [11:9] of the instruction are not stored.
   logic [3:0]  ir_op_reg;
   logic [8:0]  ir_addr_reg;
   logic        z_reg;

   logic [3:0]  alu_op;
   logic        ld_pc, inc_pc, ld_ar, ld_ir, ld_ac, ld_r, clr_ac;
   logic [15:0] ac_data;

   logic [15:0] iram_mem [0:511];
   logic [15:0] dram_mem [0:511];
   logic [15:0] iram_q, dram_q;
   logic [8:0]  iram_addr, dram_raddr, dram_waddr;
   logic        iram_we, iram_re, dram_we_ext, dram_we, dram_re;
   logic [15:0] dram_wdata;

   // ---------------- memories ----------------
   // While stopped, addr_ext drives the read ports so loaded words can be
   // read back; while running, PC and AR address the RAMs.
   assign iram_addr   = start ? pc_reg[8:0] : addr_ext;
   assign iram_we     = !start && start_2 && iram_write_ext;
   assign iram_re     = !start || read_en[0];

   assign dram_raddr  = start ? ar_reg[8:0] : addr_ext;
   assign dram_we_ext = !start && !start_2 && start_3 && dram_write_ext;
   assign dram_we     = write_en || dram_we_ext;
   assign dram_waddr  = write_en ? ar_reg[8:0] : addr_ext;
   assign dram_wdata  = write_en ? ac_reg : Data_in_dram;
   assign dram_re     = !start || read_en[1];

   always_ff @(posedge clock) begin
      if (iram_we)
         iram_mem[addr_ext] <= Data_in_ins;
      if (iram_re)
         iram_q <= iram_mem[iram_addr];
   end

   always_ff @(posedge clock) begin
      if (dram_we)
         dram_mem[dram_waddr] <= dram_wdata;
      if (dram_re)
         dram_q <= dram_mem[dram_raddr];
   end

   assign iram_in = iram_q;
   assign dram_in = dram_q;

   // ---------------- ALU ----------------
   assign alu_in_1 = ac_reg;
   assign alu_in_2 = r_reg;

   always_comb begin
      alu_out = alu_in_1;
      case (alu_op)
         ALU_PASSA: alu_out = alu_in_1;
         ALU_PASSB: alu_out = alu_in_2;
         ALU_ADD:   alu_out = alu_in_1 + alu_in_2;
         ALU_SUB:   alu_out = alu_in_1 - alu_in_2;
         ALU_INC:   alu_out = alu_in_1 + 16'd1;
         ALU_AND:   alu_out = alu_in_1 & alu_in_2;
         ALU_OR:    alu_out = alu_in_1 | alu_in_2;
         ALU_MUL:   alu_out = alu_in_1 * alu_in_2;   // low 16 bits of product
         default:   alu_out = alu_in_1;
      endcase
   end

   // LD2 is the only state that loads AC from memory instead of the ALU.
   assign ac_data    = (state_reg == S_LD2) ? dram_in : alu_out;
   assign data_in_pc = ld_pc ? {7'd0, ir_addr_reg} : pc_reg + 16'd1;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      if (!start) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE:   state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
               case (ir_op_reg)
                  4'h1:                state_next = S_LD1;
                  4'h2:                state_next = S_ST;
                  4'h8, 4'h9, 4'hA:    state_next = S_JMP;
                  4'hF:                state_next = S_HALT;
                  default:             state_next = S_ALU;   // NOP and register/ALU ops
               endcase
            end
            S_LD1:    state_next = S_LD2;
            S_LD2, S_ST, S_ALU, S_JMP: state_next = S_FETCH1;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      alu_op   = ALU_PASSA;
      write_en = 1'b0;
      read_en  = 2'b00;
      ld_pc    = 1'b0;
      inc_pc   = 1'b0;
      ld_ar    = 1'b0;
      ld_ir    = 1'b0;
      ld_ac    = 1'b0;
      ld_r     = 1'b0;
      clr_ac   = 1'b0;
      case (state_reg)
         S_FETCH1: read_en = 2'b01;
         S_FETCH2: begin ld_ir = 1'b1; inc_pc = 1'b1; end
         S_DECODE: ld_ar = 1'b1;
         S_LD1:    read_en = 2'b10;
         S_LD2:    ld_ac = 1'b1;
         S_ST:     write_en = 1'b1;
         S_ALU: begin
            case (ir_op_reg)
               4'h3: ld_r = 1'b1;
               4'h4: begin ld_ac = 1'b1; alu_op = ALU_PASSB; end
               4'h5: begin ld_ac = 1'b1; alu_op = ALU_ADD;   end
               4'h6: begin ld_ac = 1'b1; alu_op = ALU_SUB;   end
               4'h7: begin ld_ac = 1'b1; alu_op = ALU_INC;   end
               4'hB: clr_ac = 1'b1;
               4'hC: begin ld_ac = 1'b1; alu_op = ALU_AND;   end
               4'hD: begin ld_ac = 1'b1; alu_op = ALU_OR;    end
               4'hE: begin ld_ac = 1'b1; alu_op = ALU_MUL;   end
               default: ;
            endcase
         end
         S_JMP: begin
            case (ir_op_reg)
               4'h8:    ld_pc = 1'b1;
               4'h9:    ld_pc = z_reg;
               4'hA:    ld_pc = !z_reg;
               default: ld_pc = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_reg      <= 16'd1;
         ar_reg      <= 16'd0;
         ir_op_reg   <= 4'd0;
         ir_addr_reg <= 9'd0;
         ac_reg      <= 16'd0;
         r_reg       <= 16'd0;
         z_reg       <= 1'b0;
      end else begin
         if (ld_pc || inc_pc)
            pc_reg <= data_in_pc;
         if (ld_ar)
            ar_reg <= {7'd0, ir_addr_reg};
         if (ld_ir) begin
            ir_op_reg   <= iram_in[15:12];
            ir_addr_reg <= iram_in[8:0];
         end
         if (ld_r)
            r_reg <= ac_reg;
         if (clr_ac) begin
            ac_reg <= 16'd0;
            z_reg  <= 1'b1;
         end else if (ld_ac) begin
            ac_reg <= ac_data;
            z_reg  <= (ac_data == 16'd0);
         end
      end
   end

   assign pc_out      = pc_reg;
   assign ar_out      = ar_reg;
   assign dram_out    = ac_reg;
   assign state       = state_reg;
   assign control_out = {alu_op, write_en, read_en, ld_pc, inc_pc, ld_ar,
                         ld_ir, ld_ac, ld_r, clr_ac, 6'd0};

endmodule

// File: tb/tb_top_control.sv
module tb_top_control;

   logic        clock = 1'b0;
   logic        reset, start, start_2, start_3;
   logic [8:0]  addr_ext;
   logic        iram_write_ext, dram_write_ext;
   logic [15:0] Data_in_ins, Data_in_dram;
   logic [15:0] iram_in, dram_in, dram_out, pc_out, ar_out;
   logic [19:0] control_out;
   logic [5:0]  state;
   logic [15:0] data_in_pc, alu_in_1, alu_in_2, alu_out;
   logic        write_en;
   logic [1:0]  read_en;

   top_control dut (
      .clock(clock), .reset(reset), .start(start), .start_2(start_2), .start_3(start_3),
      .addr_ext(addr_ext), .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
      .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
      .iram_in(iram_in), .dram_in(dram_in), .dram_out(dram_out),
      .pc_out(pc_out), .ar_out(ar_out), .control_out(control_out), .state(state),
      .data_in_pc(data_in_pc), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
      .write_en(write_en), .read_en(read_en)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];
   logic [15:0] prog_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, act, exp);
      end else begin
         $display("ok   %s: got=%h", tag, act);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic observe(input logic [31:0] act);
      string       t;
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check(t, act, e);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic load_iram(input logic [8:0] a, input logic [15:0] d);
      @(negedge clock);
      start_2 = 1'b1; addr_ext = a; Data_in_ins = d; iram_write_ext = 1'b1;
      @(negedge clock);
      start_2 = 1'b0; iram_write_ext = 1'b0;
   endtask

   task automatic load_dram(input logic [8:0] a, input logic [15:0] d);
      @(negedge clock);
      start_3 = 1'b1; addr_ext = a; Data_in_dram = d; dram_write_ext = 1'b1;
      @(negedge clock);
      start_3 = 1'b0; dram_write_ext = 1'b0;
   endtask

   task automatic read_iram(input logic [8:0] a, output logic [15:0] d);
      @(negedge clock);
      addr_ext = a;
      @(posedge clock);
      #1 d = iram_in;
   endtask

   task automatic read_dram(input logic [8:0] a, output logic [15:0] d);
      @(negedge clock);
      addr_ext = a;
      @(posedge clock);
      #1 d = dram_in;
   endtask

   task automatic load_prog();
      for (int i = 0; i < prog_q.size(); i++)
         load_iram(9'(i + 1), prog_q[i]);
   endtask

   // Runs from reset until HALT; leaves start high and the core halted.
   task automatic run_to_halt(output int cycles);
      do_reset();
      start = 1'b1;
      cycles = 0;
      while (state !== 6'd63 && cycles < 300) begin
         @(posedge clock);
         #1 cycles++;
      end
      if (state !== 6'd63)
         check("halt_timeout", 32'(state), 32'd63);
   endtask

   task automatic stop_core();
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #1;
   endtask

   int          cyc;
   logic [15:0] rd;

   initial begin
      reset = 1'b1; start = 1'b0; start_2 = 1'b0; start_3 = 1'b0;
      addr_ext = '0; iram_write_ext = 1'b0; dram_write_ext = 1'b0;
      Data_in_ins = '0; Data_in_dram = '0;
      do_reset();

      // Preload and readback
      load_iram(9'd1, 16'h1005);
      load_dram(9'd5, 16'h0007);
      expect_val("preload_iram1", 32'h1005); read_iram(9'd1, rd); observe(32'(rd));
      expect_val("preload_dram5", 32'h0007); read_dram(9'd5, rd); observe(32'(rd));

      // start_2 has priority over start_3
      load_dram(9'd40, 16'h1234);
      @(negedge clock);
      start_2 = 1'b1; start_3 = 1'b1; iram_write_ext = 1'b1; dram_write_ext = 1'b1;
      addr_ext = 9'd40; Data_in_ins = 16'hAAAA; Data_in_dram = 16'h5555;
      @(negedge clock);
      start_2 = 1'b0; start_3 = 1'b0; iram_write_ext = 1'b0; dram_write_ext = 1'b0;
      expect_val("prio_iram40", 32'hAAAA); read_iram(9'd40, rd); observe(32'(rd));
      expect_val("prio_dram40", 32'h1234); read_dram(9'd40, rd); observe(32'(rd));

      // Reset state
      do_reset();
      #1;
      expect_val("rst_pc", 32'd1);       observe(32'(pc_out));
      expect_val("rst_ar", 32'd0);       observe(32'(ar_out));
      expect_val("rst_state", 32'd0);    observe(32'(state));
      expect_val("rst_control", 32'd0);  observe(32'(control_out));
      expect_val("rst_read_en", 32'd0);  observe(32'(read_en));
      expect_val("rst_write_en", 32'd0); observe(32'(write_en));

      // Load / add / store
      prog_q = '{16'h1005, 16'h3000, 16'h5000, 16'h2006, 16'hF000};
      load_prog();
      load_dram(9'd6, 16'h0000);
      run_to_halt(cyc);
      expect_val("las_cycles", 32'd21); observe(32'(cyc));
      expect_val("las_state", 32'd63);  observe(32'(state));
      expect_val("las_pc", 32'd6);      observe(32'(pc_out));
      expect_val("las_ac", 32'd14);     observe(32'(alu_in_1));
      expect_val("las_r", 32'd7);       observe(32'(alu_in_2));
      expect_val("las_dram_out", 32'd14); observe(32'(dram_out));
      stop_core();
      expect_val("las_stop_state", 32'd0); observe(32'(state));
      expect_val("las_dram6", 32'd14); read_dram(9'd6, rd); observe(32'(rd));

      // Conditional jumps
      load_iram(9'd10, 16'hF000);
      prog_q = '{16'hB000, 16'h900A, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("jmpz_taken_pc", 32'd11); observe(32'(pc_out));
      stop_core();

      prog_q = '{16'hB000, 16'h7000, 16'h900A, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("jmpz_fall_pc", 32'd5); observe(32'(pc_out));
      stop_core();

      prog_q = '{16'hB000, 16'h7000, 16'hA00A, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("jmpnz_taken_pc", 32'd11); observe(32'(pc_out));
      stop_core();

      // Wrap: 0 - 1 = FFFF, then INC -> 0 with Z set (JMPZ taken)
      load_iram(9'd30, 16'hF000);
      prog_q = '{16'hB000, 16'h7000, 16'h3000, 16'hB000, 16'h6000,
                 16'h2014, 16'h7000, 16'h901E, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("wrap_pc", 32'd31); observe(32'(pc_out));
      expect_val("wrap_ac", 32'd0);  observe(32'(alu_in_1));
      stop_core();
      expect_val("wrap_dram20", 32'hFFFF); read_dram(9'd20, rd); observe(32'(rd));

      // MUL: 0x0100^2 -> 0, 0x0123^2 -> 0x4AC9
      load_dram(9'd5, 16'h0100);
      load_dram(9'd7, 16'h0123);
      prog_q = '{16'h1005, 16'h3000, 16'hE000, 16'h2015,
                 16'h1007, 16'h3000, 16'hE000, 16'h2016, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("mul_pc", 32'd10);    observe(32'(pc_out));
      expect_val("mul_ac", 32'h4AC9);  observe(32'(alu_in_1));
      stop_core();
      expect_val("mul_dram21", 32'h0000); read_dram(9'd21, rd); observe(32'(rd));
      expect_val("mul_dram22", 32'h4AC9); read_dram(9'd22, rd); observe(32'(rd));

      // AND / OR / MVRAC / NOP
      load_dram(9'd8, 16'h0F0F);
      load_dram(9'd9, 16'h00FF);
      prog_q = '{16'h1009, 16'h3000, 16'h1008, 16'hC000, 16'h2017, 16'h1008,
                 16'hD000, 16'h2018, 16'h4000, 16'h0000, 16'hF000};
      load_prog();
      run_to_halt(cyc);
      expect_val("logic_pc", 32'd12);    observe(32'(pc_out));
      expect_val("logic_ac", 32'h00FF);  observe(32'(alu_in_1));
      stop_core();
      expect_val("and_dram23", 32'h000F); read_dram(9'd23, rd); observe(32'(rd));
      expect_val("or_dram24", 32'h0FFF);  read_dram(9'd24, rd); observe(32'(rd));

      // start dropped during LD1
      prog_q = '{16'h1005, 16'hF000};
      load_prog();
      do_reset();
      start = 1'b1;
      cyc = 0;
      while (state !== 6'd4 && cyc < 20) begin
         @(posedge clock);
         #1 cyc++;
      end
      if (state !== 6'd4)
         check("ld1_timeout", 32'(state), 32'd4);
      stop_core();
      expect_val("drop_state", 32'd0); observe(32'(state));
      expect_val("drop_ar", 32'd5);    observe(32'(ar_out));
      expect_val("drop_pc", 32'd2);    observe(32'(pc_out));

      // Load strobes ignored while start=1 (reset held so the core stays put)
      @(negedge clock);
      reset = 1'b1; start = 1'b1;
      start_2 = 1'b1; iram_write_ext = 1'b1; addr_ext = 9'd1; Data_in_ins = 16'hDEAD;
      @(negedge clock);
      start_2 = 1'b0; iram_write_ext = 1'b0;
      start_3 = 1'b1; dram_write_ext = 1'b1; addr_ext = 9'd5; Data_in_dram = 16'hBEEF;
      @(negedge clock);
      start_3 = 1'b0; dram_write_ext = 1'b0; start = 1'b0; reset = 1'b0;
      expect_val("ignore_iram1", 32'h1005); read_iram(9'd1, rd); observe(32'(rd));
      expect_val("ignore_dram5", 32'h0100); read_dram(9'd5, rd); observe(32'(rd));

      // Asynchronous reset mid-run
      do_reset();
      start = 1'b1;
      repeat (7) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      expect_val("midrst_pc", 32'd1);       observe(32'(pc_out));
      expect_val("midrst_ar", 32'd0);       observe(32'(ar_out));
      expect_val("midrst_state", 32'd0);    observe(32'(state));
      expect_val("midrst_write_en", 32'd0); observe(32'(write_en));
      expect_val("midrst_read_en", 32'd0);  observe(32'(read_en));
      @(negedge clock);
      start = 1'b0;
      reset = 1'b0;

      if (exp_q.size() != 0)
         check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
